// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: decides register enables/flushes and PC write.
// Control outputs are combinational (zero latency); halt and the perf counters are registered.
module pipeline_hazard_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mm_dREN,
    input  logic        mm_dWEN,
    input  logic        mm_halt,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_redirect,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmm_en,
    output logic        exmm_flush,
    output logic        mmwb_en,
    output logic        mmwb_flush,
    output logic        halt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic        ihit_q, ihit_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic fetch_ok;
    logic dstall;
    logic lu_haz;
    logic redirect_taken;

    assign fetch_ok = ihit | ihit_q;
    assign dstall   = (mm_dREN | mm_dWEN) & ~dhit;
    assign lu_haz   = ex_dREN & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    always_comb begin
        state_d        = state_q;
        ihit_d         = ihit_q;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        redirect_taken = 1'b0;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_en        = 1'b1;
        idex_flush     = 1'b0;
        exmm_en        = 1'b1;
        exmm_flush     = 1'b0;
        mmwb_en        = 1'b1;
        mmwb_flush     = 1'b0;

        if (state_q == RUN) begin
            if (dstall) begin
                // Freeze everything up to MEM; bubble into WB until the data access returns.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_en    = 1'b0;
                exmm_en    = 1'b0;
                mmwb_flush = 1'b1;
            end else if (mm_halt) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                exmm_flush = 1'b1;
                state_d    = HALTED;
            end else if (ex_redirect) begin
                ifid_flush     = 1'b1;
                idex_flush     = 1'b1;
                redirect_taken = 1'b1;
            end else if (lu_haz) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!fetch_ok) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end

            // Remember a fetch that completed while the PC was held, so it is not refetched.
            if (pc_en || ex_redirect) begin
                ihit_d = 1'b0;
            end else if (ihit) begin
                ihit_d = 1'b1;
            end

            if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (redirect_taken && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end else begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            exmm_en = 1'b0;
            mmwb_en = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            ihit_q      <= 1'b0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            ihit_q      <= ihit_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halt      = (state_q == HALTED);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; a monitor checks each cycle against queued expectations.
module tb_pipeline_hazard_ctrl;

    logic        CLK;
    logic        nRST;
    logic        ihit, dhit, mm_dREN, mm_dWEN, mm_halt, ex_dREN, id_uses_rt, ex_redirect;
    logic [4:0]  ex_rd, id_rs, id_rt;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmm_en, exmm_flush, mmwb_en, mmwb_flush, halt;
    logic [31:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mm_dREN(mm_dREN), .mm_dWEN(mm_dWEN), .mm_halt(mm_halt),
        .ex_dREN(ex_dREN), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmm_en(exmm_en), .exmm_flush(exmm_flush),
        .mmwb_en(mmwb_en), .mmwb_flush(mmwb_flush),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmm_en, exmm_flush, mmwb_en, mmwb_flush}
    localparam logic [8:0] ADV = 9'b1_10_10_10_10;
    localparam logic [8:0] DST = 9'b0_00_00_00_11;
    localparam logic [8:0] HLT = 9'b0_11_11_11_10;
    localparam logic [8:0] RED = 9'b1_11_11_10_10;
    localparam logic [8:0] LU  = 9'b0_00_11_10_10;
    localparam logic [8:0] NOF = 9'b0_11_10_10_10;
    localparam logic [8:0] OFF = 9'b0_00_00_00_00;

    typedef struct {
        logic [8:0]  ctl;
        logic        hlt;
        logic [31:0] sc;
        logic [31:0] fc;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec_id = 0;
    logic stim_done = 1'b0;

    logic [8:0] ctl_act;
    assign ctl_act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                      exmm_en, exmm_flush, mmwb_en, mmwb_flush};

    task automatic clr();
        ihit = 0; dhit = 0; mm_dREN = 0; mm_dWEN = 0; mm_halt = 0;
        ex_dREN = 0; ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_redirect = 0;
    endtask

    // Inputs are already applied; queue the expectation and let one clock edge commit the cycle.
    task automatic step(input logic [8:0] ctl, input logic hlt,
                        input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        e.ctl = ctl; e.hlt = hlt; e.sc = sc; e.fc = fc; e.id = vec_id;
        exp_q.push_back(e);
        vec_id++;
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (ctl_act !== e.ctl) begin
                bad++;
                $display("FAIL ctl vec=%0d got=%b want=%b", e.id, ctl_act, e.ctl);
            end
            total++;
            if (halt !== e.hlt) begin
                bad++;
                $display("FAIL halt vec=%0d got=%b want=%b", e.id, halt, e.hlt);
            end
            total++;
            if (stall_cnt !== e.sc) begin
                bad++;
                $display("FAIL stall_cnt vec=%0d got=%0d want=%0d", e.id, stall_cnt, e.sc);
            end
            total++;
            if (flush_cnt !== e.fc) begin
                bad++;
                $display("FAIL flush_cnt vec=%0d got=%0d want=%0d", e.id, flush_cnt, e.fc);
            end
        end
    end

    initial begin
        nRST = 1'b0;
        clr();
        @(posedge CLK);
        #1;
        // In reset: RUN behaviour with no pending fetch.
        step(NOF, 0, 0, 0);
        nRST = 1'b1;

        // Normal flow.
        for (int i = 0; i < 10; i++) begin
            clr(); ihit = 1;
            step(ADV, 0, 0, 0);
        end

        // Data stall for 3 cycles, fetch completes on the first one.
        clr(); mm_dREN = 1; ihit = 1; step(DST, 0, 0, 0);
        clr(); mm_dREN = 1;           step(DST, 0, 1, 0);
        clr(); mm_dWEN = 1;           step(DST, 0, 2, 0);
        clr(); mm_dREN = 1; dhit = 1; step(ADV, 0, 3, 0);
        clr(); ihit = 1;              step(ADV, 0, 3, 0);

        // Load-use via rs, then via rt; the held fetch is served from ihit_q next cycle.
        clr(); ihit = 1; ex_dREN = 1; ex_rd = 8; id_rs = 8; step(LU, 0, 3, 0);
        clr(); ex_dREN = 1; ex_rd = 0; id_rs = 0;            step(ADV, 0, 4, 0);
        clr(); ihit = 1; ex_dREN = 1; ex_rd = 5; id_rs = 3; id_rt = 5; id_uses_rt = 1;
        step(LU, 0, 4, 0);
        clr(); ex_dREN = 1; ex_rd = 5; id_rs = 3; id_rt = 5;  step(ADV, 0, 5, 0);

        // No fetch.
        clr(); step(NOF, 0, 5, 0);

        // Redirect, redirect over load-use, then stall over redirect.
        clr(); ex_redirect = 1; step(RED, 0, 6, 0);
        clr(); ex_redirect = 1; ex_dREN = 1; ex_rd = 8; id_rs = 8; step(RED, 0, 6, 1);
        clr(); ex_redirect = 1; mm_dREN = 1; step(DST, 0, 6, 2);
        clr(); ihit = 1; step(ADV, 0, 7, 2);

        // Reset mid-stall with ihit_q set.
        clr(); mm_dREN = 1; ihit = 1; step(DST, 0, 7, 2);
        clr(); mm_dREN = 1; nRST = 1'b0; step(DST, 0, 0, 0);
        nRST = 1'b1;
        clr(); step(NOF, 0, 0, 0);

        // Halt: sticky, ignores hits and hazards, counters frozen.
        clr(); ihit = 1; mm_halt = 1; step(HLT, 0, 1, 0);
        clr(); ihit = 1; mm_dREN = 1; ex_redirect = 1; step(OFF, 1, 2, 0);
        clr(); ihit = 1; dhit = 1;                     step(OFF, 1, 2, 0);
        clr(); step(OFF, 1, 2, 0);
        clr(); nRST = 1'b0; step(NOF, 0, 0, 0);
        nRST = 1'b1;
        clr(); ihit = 1; step(ADV, 0, 0, 0);
        clr();
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge CLK);
            budget++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
